// File: rtl/mvm_pkg.sv
// Shared constants and FSM state encoding for the MVM host streamer.
package mvm_pkg;
   localparam int DIM    = 4;
   localparam int IDX_W  = 2;
   localparam int DATA_W = 8;
   localparam int NENT   = DIM * DIM;
   localparam int FLAT_W = 2 * IDX_W;

   localparam logic [IDX_W-1:0]  EOM_ROW  = 2'd3;
   localparam logic [IDX_W-1:0]  EOM_COL  = 2'd3;
   localparam logic [FLAT_W-1:0] LAST_IDX = '1;

   typedef enum logic [2:0] {
      IDLE, SCAN, SEND, EOM, RECV, DONE
   } state_e;
endpackage

// File: rtl/mvm_host_regfile.sv
// 4x4 matrix storage: synchronous write, combinational read, cleared on reset.
module mvm_host_regfile
   import mvm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [FLAT_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [FLAT_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [NENT-1:0][DATA_W-1:0] mem_q;

   always_ff @(posedge clk) begin
      if (!rst_n)  mem_q <= '0;
      else if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/mvm_host_streamer.sv
// Streams the nonzero entries of a 4x4 matrix to the accelerator, then collects 4 results.
// Optional handshake watchdog: define MVM_HOST_TIMEOUT_EN.
module mvm_host_streamer
   import mvm_pkg::*;
`ifdef MVM_HOST_TIMEOUT_EN
   #(parameter int TIMEOUT_CYCLES = 1024)
`endif
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_row,
   input  logic [IDX_W-1:0]      wr_col,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [4:0]            nnz_count,
   output logic [DIM*DATA_W-1:0] res_data,
   output logic [DATA_W-1:0]     link_data,
   output logic                  link_sending,
   output logic [IDX_W-1:0]      link_row,
   output logic [IDX_W-1:0]      link_col,
   output logic                  link_rx_ready,
   input  logic                  acc_ready,
   input  logic                  acc_sending,
   input  logic [DATA_W-1:0]     acc_data
);
   state_e                      state_q, state_d;
   logic [FLAT_W-1:0]           idx_q, idx_d;
   logic [IDX_W-1:0]            k_q, k_d;
   logic                        busy_q, busy_d, done_q, done_d;
   logic [4:0]                  nnz_q, nnz_d;
   logic [DIM-1:0][DATA_W-1:0]  res_q, res_d;
   logic [DATA_W-1:0]           ldata_q, ldata_d;
   logic [IDX_W-1:0]            lrow_q, lrow_d, lcol_q, lcol_d;
   logic                        lsend_q, lsend_d, lrx_q, lrx_d;
   logic [DATA_W-1:0]           rd_data;
   logic                        tmo_hit;

   mvm_host_regfile u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en & ~busy_q),
      .waddr ({wr_row, wr_col}),
      .wdata (wr_data),
      .raddr (idx_q),
      .rdata (rd_data)
   );

`ifdef MVM_HOST_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_q;
   logic             err_q, counting, progress;

   assign counting = (state_q == SEND) || (state_q == EOM) || (state_q == RECV);
   assign progress = ((state_q == SEND || state_q == EOM) && acc_ready) ||
                     ((state_q == RECV) && acc_sending);
   assign tmo_hit  = counting && !progress && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= (!counting || progress) ? '0 : tmo_q + 1'b1;
         if (state_q == IDLE && start) err_q <= 1'b0;
         else if (tmo_hit)             err_q <= 1'b1;
      end
   end
   assign err = err_q;
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         nnz_q   <= '0;
         res_q   <= '0;
         ldata_q <= '0;
         lrow_q  <= '0;
         lcol_q  <= '0;
         lsend_q <= 1'b0;
         lrx_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         nnz_q   <= nnz_d;
         res_q   <= res_d;
         ldata_q <= ldata_d;
         lrow_q  <= lrow_d;
         lcol_q  <= lcol_d;
         lsend_q <= lsend_d;
         lrx_q   <= lrx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      k_d     = k_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      nnz_d   = nnz_q;
      res_d   = res_q;
      ldata_d = ldata_q;
      lrow_d  = lrow_q;
      lcol_d  = lcol_q;
      lsend_d = lsend_q;
      lrx_d   = lrx_q;
      unique case (state_q)
         IDLE: if (start) begin
            state_d = SCAN;
            busy_d  = 1'b1;
            idx_d   = '0;
            nnz_d   = '0;
            res_d   = '0;
         end
         SCAN: begin
            if (rd_data != '0) begin
               state_d = SEND;
               ldata_d = rd_data;
               lrow_d  = idx_q[FLAT_W-1:IDX_W];
               lcol_d  = idx_q[IDX_W-1:0];
               lsend_d = 1'b1;
            end else if (idx_q == LAST_IDX) begin
               state_d = EOM;
               ldata_d = '0;
               lrow_d  = EOM_ROW;
               lcol_d  = EOM_COL;
               lsend_d = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         SEND: begin
            if (acc_ready) begin
               nnz_d = nnz_q + 5'd1;
               // The last entry goes straight to the marker beat, so link_sending stays up.
               if (idx_q == LAST_IDX) begin
                  state_d = EOM;
                  ldata_d = '0;
                  lrow_d  = EOM_ROW;
                  lcol_d  = EOM_COL;
               end else begin
                  state_d = SCAN;
                  idx_d   = idx_q + 1'b1;
                  lsend_d = 1'b0;
               end
            end else if (tmo_hit) begin
               state_d = DONE;
               lsend_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         EOM: begin
            if (acc_ready) begin
               state_d = RECV;
               lsend_d = 1'b0;
               lrx_d   = 1'b1;
               k_d     = '0;
            end else if (tmo_hit) begin
               state_d = DONE;
               lsend_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         RECV: begin
            if (acc_sending) begin
               res_d[k_q] = acc_data;
               k_d        = k_q + 1'b1;
               if (k_q == IDX_W'(DIM - 1)) begin
                  state_d = DONE;
                  lrx_d   = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else if (tmo_hit) begin
               state_d = DONE;
               lrx_d   = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign nnz_count     = nnz_q;
   assign res_data      = res_q;
   assign link_data     = ldata_q;
   assign link_sending  = lsend_q;
   assign link_row      = lrow_q;
   assign link_col      = lcol_q;
   assign link_rx_ready = lrx_q;
endmodule

// File: tb/tb_mvm_host_streamer.sv
// Randomized bench: accelerator model on the link, matrix model, expected beat list per run.
module tb_mvm_host_streamer;
   logic        clk = 1'b0;
   logic        rst_n, wr_en, start;
   logic [1:0]  wr_row, wr_col;
   logic [7:0]  wr_data;
   logic        busy, done, err, link_sending, link_rx_ready;
   logic [4:0]  nnz_count;
   logic [31:0] res_data;
   logic [7:0]  link_data, acc_data;
   logic [1:0]  link_row, link_col;
   logic        acc_ready, acc_sending;

   always #5 clk = ~clk;

`ifdef MVM_HOST_TIMEOUT_EN
   mvm_host_streamer #(.TIMEOUT_CYCLES(8)) dut (
`else
   mvm_host_streamer dut (
`endif
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
      .wr_data(wr_data), .start(start), .busy(busy), .done(done), .err(err),
      .nnz_count(nnz_count), .res_data(res_data), .link_data(link_data),
      .link_sending(link_sending), .link_row(link_row), .link_col(link_col),
      .link_rx_ready(link_rx_ready), .acc_ready(acc_ready), .acc_sending(acc_sending),
      .acc_data(acc_data));

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] r;
      logic [1:0] c;
      logic [7:0] hold;
   } beat_t;

   int n_cmp = 0, n_err = 0;
   logic [7:0] mdl [16];
   beat_t      beats[$];
   logic [7:0] caps[$];
   int  scan_cyc, busy_cyc, hold, stall_cnt, rx_miss;
   int  ready_pct = 100, send_pct = 100, stall_n = 0;
   bit  seq_res = 0, prev_stall = 0;
   logic [11:0] prev_beat;
   logic a_rdy, a_snd;
   logic [7:0] a_dat;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {busy, done, err, nnz_count, res_data, link_data, link_sending,
              link_row, link_col, link_rx_ready};
   endfunction

   // Accelerator side: inputs change and outputs are observed on the falling edge.
   always @(negedge clk) begin
      a_rdy = ($urandom_range(99) < ready_pct);
      if (link_sending && stall_cnt < stall_n) a_rdy = 1'b0;
      else if (link_sending && stall_cnt >= 6 && ready_pct > 0) a_rdy = 1'b1;
      a_snd = ($urandom_range(99) < send_pct) || (link_rx_ready && rx_miss >= 5);
      a_dat = seq_res ? 8'((caps.size() + 1) * 17) : 8'($urandom);
      acc_ready = a_rdy; acc_sending = a_snd; acc_data = a_dat;
      if (rst_n) begin
         if (busy) busy_cyc++;
         if (busy && !link_sending && !link_rx_ready) scan_cyc++;
         if (link_sending) begin
            if (prev_stall) chk("hold_stable", {link_data, link_row, link_col}, prev_beat);
            hold++;
            if (a_rdy) begin
               beats.push_back({link_data, link_row, link_col, 8'(hold)});
               hold = 0; stall_cnt = 0; prev_stall = 0;
            end else begin
               stall_cnt++; prev_stall = 1;
               prev_beat = {link_data, link_row, link_col};
            end
         end else prev_stall = 0;
         if (link_rx_ready) begin
            if (a_snd) begin caps.push_back(a_dat); rx_miss = 0; end
            else rx_miss++;
         end
      end
   end

   task automatic write(input int i, input logic [7:0] v);
      wr_en = 1; wr_row = 2'(i / 4); wr_col = 2'(i % 4); wr_data = v;
      @(negedge clk);
      wr_en = 0;
      mdl[i] = v;
   endtask

   task automatic launch();
      beats.delete(); caps.delete();
      scan_cyc = 0; busy_cyc = 0; hold = 0; stall_cnt = 0; rx_miss = 0; prev_stall = 0;
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(input string tag, input bit noise, output bit seen);
      seen = 0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         if (done) seen = 1;
         else begin
            if (noise && busy) begin
               wr_en = 1'($urandom); wr_row = 2'($urandom); wr_col = 2'($urandom);
               wr_data = 8'($urandom); start = 1'($urandom);
            end else begin
               wr_en = 0; start = 0;
            end
            @(negedge clk);
         end
      end
      wr_en = 0; start = 0;
      chk({tag, "_done_seen"}, seen, 1);
   endtask

   task automatic check_run(input string tag);
      int e;
      logic [31:0] exp_res;
      e = 0;
      for (int i = 0; i < 16; i++) begin
         if (mdl[i] != 0) begin
            if (e < beats.size())
               chk({tag, "_beat"}, beats[e][19:8], {mdl[i], 2'(i / 4), 2'(i % 4)});
            e++;
         end
      end
      if (e < beats.size()) chk({tag, "_eom"}, beats[e][19:8], {8'h00, 2'd3, 2'd3});
      chk({tag, "_nbeats"}, beats.size(), e + 1);
      chk({tag, "_nnz"}, nnz_count, e);
      chk({tag, "_ncaps"}, caps.size(), 4);
      exp_res = '0;
      for (int i = 0; i < caps.size() && i < 4; i++) exp_res[8*i +: 8] = caps[i];
      chk({tag, "_res"}, res_data, exp_res);
      chk({tag, "_scan"}, scan_cyc, 16);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_busy_at_done"}, busy, 0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      bit seen;
      rst_n = 0; wr_en = 0; start = 0; wr_row = 0; wr_col = 0; wr_data = 0;
      for (int i = 0; i < 16; i++) mdl[i] = 0;
      repeat (3) @(negedge clk);
      chk("reset_outs", outs(), 0);
      rst_n = 1;
      @(negedge clk);

      // Identity matrix, ready always high, results 0x11..0x44
      for (int i = 0; i < 16; i++) write(i, (i % 5 == 0) ? 8'h01 : 8'h00);
      seq_res = 1;
      launch();
      chk("id_busy_rise", busy, 1);
      wait_done("id", 0, seen);
      chk("id_res_const", res_data, 32'h44332211);
      chk("id_busy_cycles", busy_cyc, 25);
      check_run("id");
      seq_res = 0;

      // All-zero matrix
      for (int i = 0; i < 16; i++) write(i, 8'h00);
      launch();
      wait_done("zero", 0, seen);
      check_run("zero");

      // Single entry with 5 cycles of back-pressure
      write(9, 8'hA5);
      stall_n = 5;
      launch();
      wait_done("stall", 0, seen);
      if (beats.size() > 0) chk("stall_hold", beats[0].hold, 6);
      check_run("stall");
      stall_n = 0;

      // Random matrices, random handshakes, writes/starts injected while busy
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 16; i++)
            write(i, $urandom_range(1) ? 8'h00 : (($urandom_range(7) == 0) ? 8'h80 : 8'($urandom_range(255, 1))));
         if (r == 0) write(15, 8'h80);
         ready_pct = $urandom_range(100, 40);
         send_pct  = $urandom_range(100, 40);
         stall_n   = $urandom_range(3);
         launch();
         wait_done("rnd", 1, seen);
         check_run("rnd");
      end
      ready_pct = 100; send_pct = 100; stall_n = 0;

      // Reset while an entry is being offered
      write(6, 8'h5A);
      ready_pct = 0;
      launch();
      seen = 0;
      for (int n = 0; n < 100 && !seen; n++) begin
         if (link_sending) seen = 1;
         else @(negedge clk);
      end
      chk("rst_mid_reach_send", seen, 1);
      rst_n = 0;
      @(negedge clk);
      chk("rst_mid_outs", outs(), 0);
      rst_n = 1;
      for (int i = 0; i < 16; i++) mdl[i] = 0;
      ready_pct = 100;
      @(negedge clk);
      launch();
      wait_done("post_rst", 0, seen);
      check_run("post_rst");

`ifdef MVM_HOST_TIMEOUT_EN
      write(3, 8'h3C);
      ready_pct = 0;
      launch();
      wait_done("tmo", 0, seen);
      chk("tmo_err", err, 1);
      chk("tmo_send_cycles", hold, 8);
      chk("tmo_nbeats", beats.size(), 0);
      @(negedge clk);
      chk("tmo_err_sticky", err, 1);
      ready_pct = 100;
      launch();
      chk("tmo_err_clear", err, 0);
      wait_done("tmo_rerun", 0, seen);
      check_run("tmo_rerun");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
